// File: rtl/ntru_pkg.sv
// Shared NTRU-HRSS constants and types for the coin/coefficient datapath.
package ntru_pkg;
  localparam int N_HRSS         = 701;
  localparam int COIN_W         = 256;
  localparam int BYTES_PER_WORD = 32;

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, ZERO, FIN} state_t;

  typedef logic [1:0] coef_t;
endpackage

// File: rtl/mod3_byte.sv
// Combinational byte mod 3: 16 and 4 are both 1 mod 3, so nibble and
// 2-bit digit sums fold the byte down to 0..5 before a small table.
module mod3_byte
  import ntru_pkg::*;
(
  input  logic [7:0] b,
  output coef_t      m
);
  logic [4:0] s1;
  logic [3:0] s2;
  logic [2:0] s3;

  always_comb begin
    s1 = {1'b0, b[7:4]} + {1'b0, b[3:0]};
    s2 = {1'b0, s1[4:2]} + {2'b00, s1[1:0]};
    s3 = {1'b0, s2[3:2]} + {1'b0, s2[1:0]};
    case (s3)
      3'd1, 3'd4: m = 2'd1;
      3'd2, 3'd5: m = 2'd2;
      default:    m = 2'd0;
    endcase
  end
endmodule

// File: rtl/ternary_sampler.sv
// sample_iid ternary sampler: one coin byte per coefficient, reduced mod 3,
// with the final coefficient forced to 0.
module ternary_sampler
  import ntru_pkg::*;
#(
  parameter int N     = N_HRSS,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [COIN_W:1]   coins_in,
  input  logic              coins_valid,
  output logic              coins_ready,
  output coef_t             coef_out,
  output logic [IDX_W-1:0]  coef_idx,
  output logic              coef_last,
  output logic              coef_valid,
  input  logic              coef_ready
);
  localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(N - 2);
  localparam logic [4:0]       PTR_LAST   = 5'(BYTES_PER_WORD - 1);

  state_t            state;
  logic [COIN_W:1]   word;
  logic [4:0]        ptr;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        cur_byte;
  coef_t             byte_mod;

  assign cur_byte = word[32'(ptr) * 8 + 1 +: 8];

  mod3_byte u_mod3 (.b(cur_byte), .m(byte_mod));

  // Outputs decode only registered state, so nothing flows in from inputs.
  assign coef_out = (state == EMIT) ? byte_mod : 2'd0;
  assign coef_idx = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word        <= '0;
      ptr         <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      coins_ready <= 1'b0;
      coef_valid  <= 1'b0;
      coef_last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          idx         <= '0;
          state       <= LOAD;
          busy        <= 1'b1;
          coins_ready <= 1'b1;
        end
        LOAD: if (coins_valid) begin
          word        <= coins_in;
          ptr         <= '0;
          state       <= EMIT;
          coins_ready <= 1'b0;
          coef_valid  <= 1'b1;
        end
        EMIT: if (coef_ready) begin
          idx <= idx + 1'b1;
          ptr <= ptr + 1'b1;
          if (idx == IDX_PENULT) begin
            state     <= ZERO;
            coef_last <= 1'b1;
          end else if (ptr == PTR_LAST) begin
            state       <= LOAD;
            coef_valid  <= 1'b0;
            coins_ready <= 1'b1;
          end
        end
        ZERO: if (coef_ready) begin
          state      <= FIN;
          coef_valid <= 1'b0;
          coef_last  <= 1'b0;
          done       <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          coins_ready <= 1'b0;
          coef_valid  <= 1'b0;
          coef_last   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ternary_sampler.sv
// Bench for ternary_sampler: N=5 directed word plus N=701 random runs
// checked against a byte-stream mod-3 reference model.
module tb_ternary_sampler;
  import ntru_pkg::*;

  localparam int N = N_HRSS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N=701 instance
  logic              start = 1'b0, busy, done;
  logic [COIN_W:1]   coins_in = '0;
  logic              coins_valid = 1'b0, coins_ready;
  coef_t             coef_out;
  logic [9:0]        coef_idx;
  logic              coef_last, coef_valid, coef_ready = 1'b0;

  ternary_sampler #(.N(N), .IDX_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .coins_in(coins_in), .coins_valid(coins_valid), .coins_ready(coins_ready),
    .coef_out(coef_out), .coef_idx(coef_idx), .coef_last(coef_last),
    .coef_valid(coef_valid), .coef_ready(coef_ready)
  );

  // N=5 instance
  logic              s_start = 1'b0, s_busy, s_done;
  logic [COIN_W:1]   s_coins_in = '0;
  logic              s_coins_valid = 1'b1, s_coins_ready;
  coef_t             s_coef_out;
  logic [2:0]        s_coef_idx;
  logic              s_coef_last, s_coef_valid, s_coef_ready = 1'b1;

  ternary_sampler #(.N(5), .IDX_W(3)) dut5 (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .coins_in(s_coins_in), .coins_valid(s_coins_valid), .coins_ready(s_coins_ready),
    .coef_out(s_coef_out), .coef_idx(s_coef_idx), .coef_last(s_coef_last),
    .coef_valid(s_coef_valid), .coef_ready(s_coef_ready)
  );

  logic [7:0] m_in = '0;
  coef_t      m_out;
  mod3_byte u_m (.b(m_in), .m(m_out));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-run record
  logic [COIN_W:1] words[$];
  logic [COIN_W:1] ref_words[$];
  int              got_val[$];
  int              got_idx[$];
  bit              got_last[$];
  int              ref_vals[$];
  int              r_cyc, r_xfer, stall_bad;
  bit              r_done, r_abort;

  function automatic logic [COIN_W:1] rand_word();
    logic [COIN_W:1] w;
    for (int k = 0; k < 8; k++) w[32*k+1 +: 32] = $urandom;
    return w;
  endfunction

  // Model: coefficient i is byte (i mod 32) of accepted word (i / 32), mod 3.
  function automatic int exp_coef(input int i);
    logic [COIN_W:1] w;
    logic [7:0]      b;
    if (i == N - 1) return 0;
    if (i / 32 >= words.size()) return -1;
    w = words[i / 32];
    b = w[8 * (i % 32) + 1 +: 8];
    return int'(b) % 3;
  endfunction

  task automatic run_poly(input int ready_pct, input int gap_pct, input bit replay,
                          input bit noise, input int abort_at);
    bit   was_stall = 1'b0;
    int   p_out = 0, p_idx = 0;
    bit   p_last = 1'b0;
    words.delete(); got_val.delete(); got_idx.delete(); got_last.delete();
    r_cyc = 0; r_xfer = 0; stall_bad = 0; r_done = 1'b0; r_abort = 1'b0;
    @(negedge clk);
    start = 1'b1; coins_valid = 1'b0; coef_ready = 1'b0;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      start = 1'b0;
      r_cyc = c;
      if (done) begin r_done = 1'b1; break; end
      if (abort_at >= 0 && coef_valid && int'(coef_idx) == abort_at) begin
        rst = 1'b1; r_abort = 1'b1; break;
      end
      if (was_stall && (int'(coef_out) != p_out || int'(coef_idx) != p_idx || coef_last != p_last))
        stall_bad++;
      if (noise && busy) start = ($urandom_range(0, 3) == 0);
      coins_valid = ($urandom_range(0, 99) >= gap_pct);
      coef_ready  = ($urandom_range(0, 99) < ready_pct);
      coins_in    = (replay && words.size() < ref_words.size()) ? ref_words[words.size()] : rand_word();
      if (coins_ready && coins_valid) words.push_back(coins_in);
      if (coef_valid && coef_ready) begin
        got_val.push_back(int'(coef_out));
        got_idx.push_back(int'(coef_idx));
        got_last.push_back(coef_last);
        r_xfer++;
      end
      was_stall = coef_valid && !coef_ready;
      p_out = int'(coef_out); p_idx = int'(coef_idx); p_last = coef_last;
    end
    start = 1'b0; coins_valid = 1'b0; coef_ready = 1'b0;
  endtask

  task automatic check_seq(input string tag);
    int bad = 0;
    for (int i = 0; i < got_val.size(); i++)
      if (got_idx[i] != i || got_val[i] != exp_coef(i) || got_last[i] != (i == N - 1)) bad++;
    chk({tag, "_xfers"}, got_val.size(), N);
    chk({tag, "_seq_errs"}, bad, 0);
  endtask

  initial begin
    int n5_val[$], n5_idx[$], n5_last[$];
    int n5_words, n5_cyc, quiet_bad, rep_bad;
    logic [COIN_W:1] w5;

    // Reset with start held high: reset must win.
    start = 1'b1; s_start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coins_ready", coins_ready, 0);
    chk("rst_coef_valid", coef_valid, 0);
    chk("rst_coef_last", coef_last, 0);
    chk("rst_coef_out", coef_out, 0);
    chk("rst_coef_idx", coef_idx, 0);
    chk("rst5_busy", s_busy, 0);
    start = 1'b0; s_start = 1'b0;

    for (int i = 0; i < 256; i++) begin
      m_in = 8'(i);
      #1;
      chk($sformatf("mod3_%0d", i), m_out, i % 3);
    end

    @(negedge clk);
    rst = 1'b0;

    // N=5 directed word: bytes 05, 07, FF, then zeros.
    w5 = '0;
    w5[8:1] = 8'h05; w5[16:9] = 8'h07; w5[24:17] = 8'hFF; w5[32:25] = 8'h00;
    s_coins_in = w5;
    n5_words = 0; n5_cyc = 0;
    @(negedge clk); s_start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      s_start = 1'b0;
      n5_cyc = c;
      if (s_done) break;
      if (s_coins_ready && s_coins_valid) n5_words++;
      if (s_coef_valid && s_coef_ready) begin
        n5_val.push_back(int'(s_coef_out));
        n5_idx.push_back(int'(s_coef_idx));
        n5_last.push_back(int'(s_coef_last));
      end
    end
    chk("n5_done_cycle", n5_cyc, 7);
    chk("n5_xfers", n5_val.size(), 5);
    chk("n5_words", n5_words, 1);
    if (n5_val.size() == 5) begin
      chk("n5_c0", n5_val[0], 2);
      chk("n5_c1", n5_val[1], 1);
      chk("n5_c2", n5_val[2], 0);
      chk("n5_c3", n5_val[3], 0);
      chk("n5_c4", n5_val[4], 0);
      chk("n5_idx4", n5_idx[4], 4);
      chk("n5_last4", n5_last[4], 1);
      chk("n5_last3", n5_last[3], 0);
    end
    @(negedge clk);
    chk("n5_done_pulse", s_done, 0);
    chk("n5_idle_busy", s_busy, 0);

    // Full polynomial, no stalls.
    run_poly(100, 0, 1'b0, 1'b0, -1);
    chk("full_done", r_done, 1);
    chk("full_cycles", r_cyc, 724);
    chk("full_words", words.size(), 22);
    check_seq("full");
    if (got_val.size() == N) begin
      chk("full_last_idx", got_idx[N-1], N - 1);
      chk("full_last_val", got_val[N-1], 0);
    end
    ref_words = words;
    ref_vals  = got_val;
    @(negedge clk);
    chk("full_done_pulse", done, 0);
    chk("full_idle_busy", busy, 0);

    // Same coins with ready/valid gaps and stray start pulses.
    run_poly(50, 30, 1'b1, 1'b1, -1);
    chk("stall_done", r_done, 1);
    chk("stall_words", words.size(), 22);
    chk("stall_stable_errs", stall_bad, 0);
    check_seq("stall");
    rep_bad = 0;
    for (int i = 0; i < got_val.size() && i < ref_vals.size(); i++)
      if (got_val[i] != ref_vals[i]) rep_bad++;
    chk("stall_vs_nostall", rep_bad, 0);

    // Back-to-back: new polynomial must start from a fresh word.
    run_poly(100, 0, 1'b0, 1'b0, -1);
    chk("b2b_done", r_done, 1);
    chk("b2b_words", words.size(), 22);
    check_seq("b2b");

    // Abort at idx 300.
    run_poly(100, 0, 1'b0, 1'b0, 300);
    chk("abort_hit", r_abort, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_coins_ready", coins_ready, 0);
    chk("abort_coef_valid", coef_valid, 0);
    chk("abort_coef_last", coef_last, 0);
    chk("abort_coef_out", coef_out, 0);
    chk("abort_coef_idx", coef_idx, 0);
    quiet_bad = 0;
    coins_valid = 1'b1; coef_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done || coef_valid || busy) quiet_bad++;
    end
    coins_valid = 1'b0; coef_ready = 1'b0;
    chk("abort_quiet", quiet_bad, 0);

    run_poly(100, 0, 1'b0, 1'b0, -1);
    chk("restart_done", r_done, 1);
    chk("restart_cycles", r_cyc, 724);
    check_seq("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
